// File: rtl/agc_window_ctrl.sv
// One AGC measurement window: counts gt/lt threshold flags over period+1 clocks,
// then publishes the counts, their sum and their signed difference behind a valid/ack handshake.
module agc_window_ctrl #(
  parameter int CNT_BITS = 24
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                gt_i,
  input  logic                lt_i,
  input  logic                start_i,
  input  logic [CNT_BITS-1:0] period_i,
  input  logic                ack_i,
  output logic                busy_o,
  output logic                valid_o,
  output logic [CNT_BITS-1:0] gt_cnt_o,
  output logic [CNT_BITS-1:0] lt_cnt_o,
  output logic [CNT_BITS:0]   sum_o,
  output logic [CNT_BITS:0]   diff_o,
  output logic                scale_en_o
);

  typedef enum logic [1:0] {IDLE, COUNT, CALC, DONE} state_t;

  state_t              state, state_nxt;
  logic                load;
  logic [CNT_BITS-1:0] win, gt_cnt, lt_cnt;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE:  if (start_i) begin load = 1'b1; state_nxt = COUNT; end
      COUNT: if (win == '0) state_nxt = CALC;
      CALC:  state_nxt = DONE;
      DONE:  if (ack_i) begin
               if (start_i) begin load = 1'b1; state_nxt = COUNT; end
               else state_nxt = IDLE;
             end
      default: state_nxt = IDLE;
    endcase
  end

  // busy/valid registered from the next state so they line up with the state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      busy_o  <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      state   <= state_nxt;
      busy_o  <= (state_nxt != IDLE);
      valid_o <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      win        <= '0;
      gt_cnt     <= '0;
      lt_cnt     <= '0;
      gt_cnt_o   <= '0;
      lt_cnt_o   <= '0;
      sum_o      <= '0;
      diff_o     <= '0;
      scale_en_o <= 1'b0;
    end else if (load) begin
      win    <= period_i;
      gt_cnt <= '0;
      lt_cnt <= '0;
    end else if (state == COUNT) begin
      if (win != '0) win <= win - CNT_BITS'(1);
      if (gt_i && gt_cnt != '1) gt_cnt <= gt_cnt + CNT_BITS'(1);
      if (lt_i && lt_cnt != '1) lt_cnt <= lt_cnt + CNT_BITS'(1);
    end else if (state == CALC) begin
      gt_cnt_o   <= gt_cnt;
      lt_cnt_o   <= lt_cnt;
      sum_o      <= {1'b0, gt_cnt} + {1'b0, lt_cnt};
      diff_o     <= {1'b0, gt_cnt} - {1'b0, lt_cnt};
      // sticky: the scaler stays enabled once any window has completed
      scale_en_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_agc_window_ctrl.sv
// Directed bench for agc_window_ctrl: table of windows plus hand sequences for
// back-to-back, ignored requests, reset abort and counter saturation.
module tb_agc_window_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        gt, lt, start, ack;
  logic [23:0] period;
  logic        busy, valid, scale_en;
  logic [23:0] gt_cnt, lt_cnt;
  logic [24:0] sum, diff;

  logic        s_gt, s_lt, s_start, s_ack;
  logic [3:0]  s_period;
  logic        s_busy, s_valid, s_scale_en;
  logic [3:0]  s_gt_cnt, s_lt_cnt;
  logic [4:0]  s_sum, s_diff;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  agc_window_ctrl #(.CNT_BITS(24)) u_dut (
    .clk_i(clk), .rst_i(rst), .gt_i(gt), .lt_i(lt), .start_i(start),
    .period_i(period), .ack_i(ack), .busy_o(busy), .valid_o(valid),
    .gt_cnt_o(gt_cnt), .lt_cnt_o(lt_cnt), .sum_o(sum), .diff_o(diff),
    .scale_en_o(scale_en));

  agc_window_ctrl #(.CNT_BITS(4)) u_sat (
    .clk_i(clk), .rst_i(rst), .gt_i(s_gt), .lt_i(s_lt), .start_i(s_start),
    .period_i(s_period), .ack_i(s_ack), .busy_o(s_busy), .valid_o(s_valid),
    .gt_cnt_o(s_gt_cnt), .lt_cnt_o(s_lt_cnt), .sum_o(s_sum), .diff_o(s_diff),
    .scale_en_o(s_scale_en));

  typedef struct {
    int          period;
    int          gt_lo, gt_hi;   // gt high on window samples [gt_lo, gt_hi)
    int          lt_lo, lt_hi;
    logic [23:0] egt, elt;
    logic [24:0] esum, ediff;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    period = v.period[23:0];
    start  = 1'b1;
    tick();                              // edge 0
    start  = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 1);
    for (int i = 0; i <= v.period; i++) begin
      gt = (i >= v.gt_lo && i < v.gt_hi);
      lt = (i >= v.lt_lo && i < v.lt_hi);
      tick();
    end
    gt = 1'b0;
    lt = 1'b0;
    chk("valid_early", {31'd0, valid}, 0);
    tick();                              // CALC edge
    chk("valid", {31'd0, valid}, 1);
    chk("scale_en", {31'd0, scale_en}, 1);
    chk("gt_cnt", {8'd0, gt_cnt}, {8'd0, v.egt});
    chk("lt_cnt", {8'd0, lt_cnt}, {8'd0, v.elt});
    chk("sum", {7'd0, sum}, {7'd0, v.esum});
    chk("diff", {7'd0, diff}, {7'd0, v.ediff});
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("valid_after_ack", {31'd0, valid}, 0);
    chk("busy_after_ack", {31'd0, busy}, 0);
  endtask

  initial begin
    vecs[0] = '{9,  0, 10, 0, 0,  24'd10, 24'd0,  25'd10, 25'd10};
    vecs[1] = '{99, 0, 30, 25, 70, 24'd30, 24'd45, 25'd75, 25'h1FFFFF1};
    vecs[2] = '{0,  0, 1,  0, 1,  24'd1,  24'd1,  25'd2,  25'd0};
    vecs[3] = '{4,  0, 0,  0, 5,  24'd0,  24'd5,  25'd5,  25'h1FFFFFB};
    vecs[4] = '{3,  0, 2,  1, 4,  24'd2,  24'd3,  25'd5,  25'h1FFFFFF};

    rst = 1'b1; gt = 0; lt = 0; start = 0; ack = 0; period = '0;
    s_gt = 0; s_lt = 0; s_start = 0; s_ack = 0; s_period = '0;
    tick(); tick();
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_valid", {31'd0, valid}, 0);
    chk("rst_scale_en", {31'd0, scale_en}, 0);
    chk("rst_gt_cnt", {8'd0, gt_cnt}, 0);
    rst = 1'b0;
    tick();

    // ack in IDLE is ignored
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("idle_ack_busy", {31'd0, busy}, 0);
    chk("idle_ack_valid", {31'd0, valid}, 0);
    chk("scale_en_before_first", {31'd0, scale_en}, 0);

    for (int k = 0; k < 4; k++) run_vec(vecs[k]);

    // start and period change mid-COUNT must not alter the window
    period = 24'd5;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    gt     = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin start = 1'b1; period = 24'd0; end
      else start = 1'b0;
      tick();
      if (i < 5) chk("ign_busy", {31'd0, busy}, 1);
    end
    gt = 1'b0;
    chk("ign_valid_early", {31'd0, valid}, 0);
    tick();
    chk("ign_valid", {31'd0, valid}, 1);
    chk("ign_gt_cnt", {8'd0, gt_cnt}, 6);

    // back-to-back: ack+start in DONE, new window period 1 with lt only
    period = 24'd1;
    ack    = 1'b1;
    start  = 1'b1;
    tick();
    ack    = 1'b0;
    start  = 1'b0;
    chk("b2b_busy0", {31'd0, busy}, 1);
    chk("b2b_valid0", {31'd0, valid}, 0);
    chk("b2b_hold_gt", {8'd0, gt_cnt}, 6);
    lt = 1'b1;
    tick();
    chk("b2b_busy1", {31'd0, busy}, 1);
    tick();
    lt = 1'b0;
    chk("b2b_busy2", {31'd0, busy}, 1);
    chk("b2b_valid_early", {31'd0, valid}, 0);
    tick();
    chk("b2b_valid", {31'd0, valid}, 1);
    chk("b2b_gt_cnt", {8'd0, gt_cnt}, 0);
    chk("b2b_lt_cnt", {8'd0, lt_cnt}, 2);
    chk("b2b_diff", {7'd0, diff}, 32'h1FFFFFE);
    chk("b2b_scale_en", {31'd0, scale_en}, 1);
    ack = 1'b1;
    tick();
    ack = 1'b0;

    // reset mid-window aborts asynchronously
    period = 24'd20;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    gt     = 1'b1;
    tick(); tick(); tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_valid", {31'd0, valid}, 0);
    chk("arst_scale_en", {31'd0, scale_en}, 0);
    chk("arst_gt_cnt", {8'd0, gt_cnt}, 0);
    chk("arst_sum", {7'd0, sum}, 0);
    gt = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    run_vec(vecs[4]);

    // saturation with a 4-bit counter
    s_period = 4'd15;
    s_start  = 1'b1;
    tick();
    s_start  = 1'b0;
    s_gt     = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    s_gt = 1'b0;
    chk("sat_valid_early", {31'd0, s_valid}, 0);
    tick();
    chk("sat_valid", {31'd0, s_valid}, 1);
    chk("sat_gt_cnt", {28'd0, s_gt_cnt}, 15);
    chk("sat_lt_cnt", {28'd0, s_lt_cnt}, 0);
    chk("sat_sum", {27'd0, s_sum}, 15);
    chk("sat_diff", {27'd0, s_diff}, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/agc_window_ctrl.md
# agc_window_ctrl

Sequences one AGC measurement window for a single channel. It counts the `gt`/`lt` threshold flags produced by the channel's saturate-and-scale stage over a programmable number of clocks, then forms the sum (gain error) and signed difference (offset/symmetry error). It presents both results to the AGC register/microcontroller side through a valid/ack handshake. It also drives the scaler's output enable so that the beamformer sees midscale (offset-binary `10000`) until the first window has completed after reset.

## Interface

Parameters:
- `CNT_BITS`, 24: width of the per-flag counters and of `period_i`.

Ports:
- `clk_i`: input, 1 bit. Sample clock, the same clock as the scaler.
- `rst_i`: input, 1 bit. Reset, asynchronous and active-high.
- `gt_i`: input, 1 bit. Scaler "greater than +threshold" flag, sampled every clock.
- `lt_i`: input, 1 bit. Scaler "less than −threshold" flag, sampled every clock.
- `start_i`: input, 1 bit. Single-cycle request to run one window.
- `period_i`: input, `CNT_BITS` bits. Window length minus 1, in clocks. Captured when the window starts.
- `ack_i`: input, 1 bit. Result consumed. Only meaningful while `valid_o` is high.
- `busy_o`: output, 1 bit. High in states COUNT, CALC and DONE.
- `valid_o`: output, 1 bit. Results on `gt_cnt_o` through `diff_o` are stable.
- `gt_cnt_o`: output, `CNT_BITS` bits. Number of window cycles with `gt_i` high, saturating.
- `lt_cnt_o`: output, `CNT_BITS` bits. Number of window cycles with `lt_i` high, saturating.
- `sum_o`: output, `CNT_BITS+1` bits. `gt_cnt_o + lt_cnt_o`, unsigned.
- `diff_o`: output, `CNT_BITS+1` bits. `gt_cnt_o − lt_cnt_o`, two's complement.
- `scale_en_o`: output, 1 bit. Enable to the scaler.

## Operation

- State machine states: IDLE, COUNT, CALC, DONE.
- Reset values (asynchronous): state IDLE; all counters 0; all outputs 0, including `scale_en_o`.
- IDLE:
  - On `start_i`, load the window counter with `period_i`, clear `gt_cnt` and `lt_cnt`, and go to COUNT.
- COUNT:
  - Each cycle, `gt_cnt` increments if `gt_i` is high and `lt_cnt` increments if `lt_i` is high. The two are independent; both increment if both flags are high.
  - Each counter saturates at all-ones and does not wrap.
  - If the window counter equals 0, that cycle's flags are still counted and the next state is CALC. Otherwise the window counter decrements.
  - A window is therefore exactly `period_i+1` sampled cycles. `period_i = 0` gives one sample.
- CALC:
  - Register `sum_o` and `diff_o` from the final counts.
  - Copy the counts to `gt_cnt_o` and `lt_cnt_o`.
  - Go to DONE.
  - Both results are `CNT_BITS+1` bits wide and never overflow. `diff_o` is a sign-extended subtraction.
- DONE:
  - `valid_o` is high. Result outputs hold constant.
  - Set `scale_en_o` to 1. It stays 1 until reset and is never cleared by later windows.
  - If `ack_i` is high and `start_i` is low, go to IDLE.
  - If `ack_i` and `start_i` are both high in the same cycle, start a new window immediately: reload, clear, go to COUNT.
- `start_i` outside IDLE (or outside DONE-with-`ack_i`) is ignored. It is not queued.
- `ack_i` outside DONE is ignored.
- `period_i` changing mid-window has no effect on the current window.
- Result outputs keep their last values after leaving DONE. Only `valid_o` qualifies them.
- Reset asserted mid-window aborts it immediately. There is no partial result, and `scale_en_o` returns to 0.

## Timing

- Let edge 0 be the edge at which `start_i` is sampled in IDLE.
- `busy_o` rises after edge 0.
- Flags are sampled at edges 1 through `period_i+1`. Call the last of these edge L.
- Edge L+1 is the CALC registration. `valid_o` and `scale_en_o` are first high after edge L+1.
- Total latency from the `start_i` edge to `valid_o` is `period_i+2` clocks.
- After `ack_i` is sampled in DONE, `valid_o` and `busy_o` drop after that edge. The exception is a simultaneous `start_i`, which keeps `busy_o` high.
- In the back-to-back case (`ack_i` and `start_i` together), the first sample of the new window is at the next edge. There is no dead cycle.
- All outputs are registered. The block contains no combinational input-to-output paths.

## Test plan

- Basic window: `period_i=9`, `gt_i=1` and `lt_i=0` constant, `start_i` at edge 0.
  - Required: `valid_o` high after edge 11, `gt_cnt_o=10`, `lt_cnt_o=0`, `sum_o=10`, `diff_o=+10`, `scale_en_o` rises with `valid_o`.
- Mixed flags: `period_i=99`, `gt_i` high on 30 cycles, `lt_i` high on 45 cycles, 5 of those cycles overlapping.
  - Required: `gt_cnt_o=30`, `lt_cnt_o=45`, `sum_o=75`, `diff_o=−15` (all-ones pattern minus 14).
- Saturation: `CNT_BITS=4`, `period_i=15`, `gt_i=1` for all 16 cycles.
  - Required: `gt_cnt_o=15`, not 0. `sum_o=15` in a 5-bit result.
- Minimum window and back-to-back runs:
  - `period_i=0` gives exactly 1 sample and `valid_o` 2 clocks after start.
  - With `ack_i` and `start_i` asserted together in DONE, the second window starts with no gap and `busy_o` never drops.
- Ignored requests: `start_i` pulsed mid-COUNT and `ack_i` pulsed in IDLE.
  - Required: the window length is unchanged and no spurious state change occurs.
- Reset mid-window: assert `rst_i` during COUNT of the first window.
  - Required: all outputs are 0 immediately (asynchronously). After release, a fresh start gives correct counts with no carryover.
